// File: rtl/dmem_responder_if.sv
// Data-memory port between the LSU (initiator) and a memory-side responder.
// The initiator holds a request until it sees the one-cycle resp pulse.
interface dmem_responder_if;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for the LSU data port: word-addressed, byte-writable
// local store with programmable response latency and stall injection.
// Read data is the pre-write word; writes commit on the edge leaving RESP.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    input  logic             stall_in,
    output logic             err,
    output logic [15:0]      req_count
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             resp_q;
    logic [31:0]      rdata_q;

    logic [31:0]      addr_lat, wdata_lat;
    logic [3:0]       rmask_lat, wmask_lat;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             req_in, accept;
    logic [31:0]      cur_addr, word_off;
    logic [3:0]       cur_rmask, cur_wmask;
    logic             in_range, bad_req;
    logic [IDX_W-1:0] idx;

    assign req_in = (bus.dmem_rmask | bus.dmem_wmask) != 4'h0;
    assign accept = (state == IDLE) && req_in;

    // The request being serviced: live inputs while idle (needed for LATENCY==1), latched copy afterwards
    always_comb begin
        cur_addr  = addr_lat;
        cur_rmask = rmask_lat;
        cur_wmask = wmask_lat;
        if (state == IDLE) begin
            cur_addr  = bus.dmem_addr;
            cur_rmask = bus.dmem_rmask;
            cur_wmask = bus.dmem_wmask;
        end
    end

    assign word_off = (cur_addr - ADDR_BASE) >> 2;
    assign in_range = (cur_addr >= ADDR_BASE) && (word_off < 32'(DEPTH_WORDS));
    assign idx      = word_off[IDX_W-1:0];
    assign bad_req  = !in_range || ((cur_rmask != 4'h0) && (cur_wmask != 4'h0));

    // Next-state logic for the IDLE -> WAIT -> RESP handshake with stall-frozen countdown
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (req_in) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (!stall_in) begin
                    if (cnt == '0) state_nxt = RESP;
                    else           cnt_nxt   = cnt - 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, response outputs, sticky error and request counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
            err       <= 1'b0;
            req_count <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            resp_q <= (state_nxt == RESP);
            if (accept) req_count <= req_count + 16'd1;
            if (state_nxt == RESP) begin
                rdata_q <= in_range ? mem[idx] : 32'h0;
                if (bad_req) err <= 1'b1;
            end
        end
    end

    // Capture the request on the accept edge; the initiator holds it, but WAIT must not depend on that
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_lat  <= bus.dmem_addr;
            rmask_lat <= bus.dmem_rmask;
            wmask_lat <= bus.dmem_wmask;
            wdata_lat <= bus.dmem_wdata;
        end
    end

    // Byte-lane write commit on the edge leaving RESP; reset clears the store and drops any pending write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (state == RESP && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_wmask[b]) mem[idx][8*b +: 8] <= wdata_lat[8*b +: 8];
            end
        end
    end

    assign bus.dmem_resp  = resp_q;
    assign bus.dmem_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: LATENCY=2 and LATENCY=1 instances.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [31:0] addr, wdata;
    logic [3:0]  rmask, wmask;
    logic        stall;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int c0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    logic        err0, err1;
    logic [15:0] cnt0, cnt1;
    logic        resp_m;
    logic [31:0] rdata_m;

    assign bus0.dmem_addr  = addr;
    assign bus0.dmem_wdata = wdata;
    assign bus0.dmem_rmask = sel ? 4'h0 : rmask;
    assign bus0.dmem_wmask = sel ? 4'h0 : wmask;
    assign bus1.dmem_addr  = addr;
    assign bus1.dmem_wdata = wdata;
    assign bus1.dmem_rmask = sel ? rmask : 4'h0;
    assign bus1.dmem_wmask = sel ? wmask : 4'h0;
    assign resp_m  = sel ? bus1.dmem_resp  : bus0.dmem_resp;
    assign rdata_m = sel ? bus1.dmem_rdata : bus0.dmem_rdata;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .ADDR_BASE(32'h0)) u_dut (
        .clk(clk), .rst(rst), .bus(bus0), .stall_in(stall & ~sel),
        .err(err0), .req_count(cnt0)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .ADDR_BASE(32'h0)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .stall_in(stall & sel),
        .err(err1), .req_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response pulse must never last two cycles on either instance
    logic prev0 = 1'b0, prev1 = 1'b0;
    always @(negedge clk) begin
        if (prev0) chk("resp0_width", 32'(bus0.dmem_resp), 32'h0);
        if (prev1) chk("resp1_width", 32'(bus1.dmem_resp), 32'h0);
        prev0 <= bus0.dmem_resp;
        prev1 <= bus1.dmem_resp;
    end

    // Drive a request now (cycle T = current cycle if idle, or next cycle if called in RESP),
    // wait for resp, check latency and scoreboard rdata, then drop the request.
    task automatic do_req(input string tag, input logic [31:0] a, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd, input logic [31:0] exp,
                          input int exp_lat, input int stalls);
        logic got;
        logic [31:0] e;
        got = 1'b0;
        exp_q.push_back(exp);
        addr = a; rmask = rm; wmask = wm; wdata = wd;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (stalls > 0 && i == 0) stall = 1'b1;
            if (i == stalls + 1) stall = 1'b0;
            if (resp_m) begin
                got = 1'b1;
                chk({tag, "_lat"}, 32'(i), 32'(exp_lat));
                e = exp_q.pop_front();
                chk({tag, "_rdata"}, rdata_m, e);
                last_cyc = cyc;
                rmask = 4'h0; wmask = 4'h0; stall = 1'b0;
            end
        end
        if (!got) begin
            chk({tag, "_timeout"}, 32'h0, 32'h1);
            void'(exp_q.pop_front());
            rmask = 4'h0; wmask = 4'h0; stall = 1'b0;
        end
    endtask

    task automatic to_idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; stall = 1'b0;
        addr = '0; wdata = '0; rmask = '0; wmask = '0;
        repeat (2) @(negedge clk);
        chk("rst_resp", 32'(bus0.dmem_resp), 32'h0);
        chk("rst_rdata", bus0.dmem_rdata, 32'h0);
        chk("rst_err", 32'(err0), 32'h0);
        chk("rst_count", 32'(cnt0), 32'h0);
        rst = 1'b0;

        // Store then back-to-back load at LATENCY=2
        to_idle();
        do_req("sw", 32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0, 2, 0);
        c0 = last_cyc;
        do_req("lw", 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF, 2, 0);
        chk("b2b_gap", 32'(last_cyc - c0), 32'd3);
        chk("count2", 32'(cnt0), 32'd2);

        // Byte-lane write returns the old word, following read sees the merge
        do_req("sb", 32'h10, 4'h0, 4'b0100, 32'h00AB0000, 32'hDEADBEEF, 2, 0);
        do_req("lw_sb", 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEABBEEF, 2, 0);

        // Three stalled WAIT cycles
        to_idle();
        do_req("stall", 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEABBEEF, 5, 3);
        chk("count5", 32'(cnt0), 32'd5);
        chk("err_clean", 32'(err0), 32'h0);

        // Out of range: one past the last word
        to_idle();
        do_req("oor_rd", 32'h400, 4'hF, 4'h0, 32'h0, 32'h0, 2, 0);
        chk("oor_err", 32'(err0), 32'h1);
        do_req("oor_wr", 32'h400, 4'h0, 4'hF, 32'hFFFFFFFF, 32'h0, 2, 0);
        do_req("word0", 32'h0, 4'hF, 4'h0, 32'h0, 32'h0, 2, 0);
        do_req("unchg", 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEABBEEF, 2, 0);
        chk("err_sticky", 32'(err0), 32'h1);

        // Reset clears control, outputs and store
        rst = 1'b1;
        #1;
        chk("rst2_err", 32'(err0), 32'h0);
        chk("rst2_count", 32'(cnt0), 32'h0);
        chk("rst2_rdata", bus0.dmem_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        to_idle();
        do_req("cleared", 32'h10, 4'hF, 4'h0, 32'h0, 32'h0, 2, 0);

        // Both masks set: behaves as a write, flags err
        do_req("rw", 32'h10, 4'hF, 4'hF, 32'h11223344, 32'h0, 2, 0);
        chk("rw_err", 32'(err0), 32'h1);
        do_req("rw_rd", 32'h10, 4'hF, 4'h0, 32'h0, 32'h11223344, 2, 0);

        // Reset during WAIT of a write to 0x20 drops it
        to_idle();
        addr = 32'h20; wmask = 4'hF; wdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        rmask = 4'h0; wmask = 4'h0;
        #1;
        chk("rstw_resp", 32'(bus0.dmem_resp), 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("rstw_noresp", 32'(bus0.dmem_resp), 32'h0);
        end
        rst = 1'b0;
        to_idle();
        do_req("rstw_rd", 32'h20, 4'hF, 4'h0, 32'h0, 32'h0, 2, 0);
        chk("rstw_count", 32'(cnt0), 32'd1);

        // LATENCY=1 instance: back-to-back gives a response every other cycle
        to_idle();
        sel = 1'b1;
        do_req("l1_sw", 32'h40, 4'h0, 4'hF, 32'hAABBCCDD, 32'h0, 1, 0);
        c0 = last_cyc;
        do_req("l1_lw", 32'h40, 4'hF, 4'h0, 32'h0, 32'hAABBCCDD, 1, 0);
        chk("l1_gap1", 32'(last_cyc - c0), 32'd2);
        c0 = last_cyc;
        do_req("l1_lw2", 32'h44, 4'hF, 4'h0, 32'h0, 32'h0, 1, 0);
        chk("l1_gap2", 32'(last_cyc - c0), 32'd2);
        chk("l1_count", 32'(cnt1), 32'd3);
        chk("l1_err", 32'(err1), 32'h0);

        to_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
